hwf_kernel_engine: RTL and testbench
====================================

Name: hwf_kernel_engine

Overview:
- Streaming hardware-friendly (HWF) SVM kernel engine.
- Computes out = Bi · 2^(−γ·‖x_test − x_sv‖₁):
  - L1 norm accumulated over LANES pixels per beat.
  - Power-of-two exponential by integer shift plus shift-add iterations driven by a log-constant table.
- Sits between the pixel/support-vector memory stage and the SVM decision accumulator.
- One kernel evaluation per start, with valid/ready handshakes on input and output.

Parameters:
- PIX_W, 8, pixel width (unsigned).
- LANES, 1, pixels consumed per input beat; must divide NUM_PIXELS.
- NUM_PIXELS, 64, pixels per vector.
- COEF_W, 16, Bi/output width, Q(COEF_W−FRAC_W).FRAC_W.
- FRAC_W, 8, fractional bits of exponent E and of log constants.
- ITER, 8, shift-add iterations (i = 1..ITER), ITER < COEF_W.
- GAMMA_SHIFT, 0, γ = 2^−GAMMA_SHIFT, 0 ≤ GAMMA_SHIFT ≤ FRAC_W.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin evaluation; sampled only in IDLE.
- bi, input, COEF_W, kernel coefficient Bi; captured when start is accepted.
- in_valid, input, 1, pixel beat valid.
- in_ready, output, 1, engine accepts beat.
- x_test, input, LANES*PIX_W, test pixels, lane 0 in LSBs.
- x_sv, input, LANES*PIX_W, support-vector pixels.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- kern_out, output, COEF_W, kernel result.
- busy, output, 1, state ≠ IDLE.

Behaviour:
- Reset (clk and rst as stated): state IDLE; in_ready=0, out_valid=0, kern_out=0, busy=0; norm, beat counter, iteration counter cleared.
  - Reset mid-operation aborts the evaluation immediately; no partial result is emitted.
- FSM states: IDLE, ACCUM, SHIFT, EXP, DONE.
- IDLE:
  - start=1 → ACCUM; capture bi; norm=0; beat_cnt=0.
  - start while not IDLE is ignored.
- ACCUM:
  - in_ready=1.
  - Per accepted beat (in_valid & in_ready): norm += Σ over lanes of |x_test[l] − x_sv[l]|, computed as an unsigned compare-and-subtract.
  - NORM_W = PIX_W + clog2(NUM_PIXELS + 1); the norm never overflows.
  - After beat NUM_PIXELS/LANES is accepted → SHIFT; in_ready drops in the next cycle.
  - in_valid low stalls with no state change.
- SHIFT (1 cycle):
  - E = (norm << FRAC_W) >> GAMMA_SHIFT, truncated.
  - ip = integer part of E; f = fractional part (FRAC_W bits).
  - B = (ip ≥ COEF_W) ? 0 : bi >> ip, logical shift.
  - r = f; i = 1.
- EXP (exactly ITER cycles, fixed latency):
  - If r ≥ C[i]: B ← B − (B >> i) and r ← r − C[i]; otherwise hold.
  - C[i] = round(−log2(1 − 2^−i) · 2^FRAC_W).
  - i increments each cycle; after i = ITER → DONE.
- DONE:
  - out_valid=1, kern_out=B; both held stable until out_ready=1.
  - On the handshake → IDLE next cycle and out_valid=0.
  - A start arriving in the same cycle as the handshake is ignored.
- Latency: last beat accepted at edge N → out_valid high after edge N+ITER+2.
- Zero norm yields kern_out = bi exactly.
- Error bound: |kern_out − bi·2^−E| ≤ ITER+2 LSB.

Optional Feature:
- Macro: HWF_SIGNED_COEF_EN.
- Defined:
  - bi is two's-complement signed.
  - Magnitude is processed through SHIFT/EXP; sign is reapplied in DONE.
  - Most negative bi saturates to −(2^(COEF_W−1) − 1) before processing.
  - Result is never −0; a zero magnitude outputs 0.
- Undefined: bi is unsigned, as described above.

Decomposition:
- Package hwf_pkg:
  - FSM state encoding.
  - clog2 helper.
  - Log-constant table C[1..16] at FRAC_W=8: 256, 106, 49, 24, 12, 6, 3, 1, 1, 0, ...
  - Function returning C[i] for a given FRAC_W.
- Sub-module hwf_l1_lanes (combinational): Σ over LANES of |a−b|, instantiated once; output width PIX_W + clog2(LANES+1).

Test Plan:
All scenarios use NUM_PIXELS=4, LANES=1, COEF_W=16, FRAC_W=8, ITER=8 unless stated.
- Identical vectors, bi=0x0100, GAMMA_SHIFT=0 → kern_out=0x0100; out_valid exactly ITER+2=10 cycles after the last beat.
- One pixel differs by 1, bi=0x0100 → E=1.0 → kern_out=0x0080.
- Pixels 0 vs 255 on all 4 → norm=1020 ≥ COEF_W → kern_out=0x0000 with the same fixed latency.
- GAMMA_SHIFT=1, norm=1, bi=0x0100 → E=0.5 → kern_out within ±10 LSB of 0x00B5.
- LANES=2, in_valid toggled every other cycle, out_ready held low 5 cycles:
  - Correct norm; kern_out stable while out_valid is high.
  - A start during busy is ignored.
  - rst asserted mid-ACCUM → all outputs 0 next cycle; a new run then gives the correct result.
- HWF_SIGNED_COEF_EN, bi=0xFF00 (−1.0), norm=1 → kern_out=0xFF80 (−0.5).

Source files
------------

// File: rtl/hwf_pkg.sv
// Shared types, sizing helper and log-constant table for the HWF SVM kernel engine.
package hwf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_SHIFT = 3'd2,
    ST_EXP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int LOG_C_FRAC  = 16;
  localparam int LOG_C_MAX_I = 16;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // C[i] = round(-log2(1 - 2^-i) * 2^8).
  function automatic logic [16:0] log_const_q8(input int i);
    logic [16:0] c;
    case (i)
      1:       c = 17'd256;
      2:       c = 17'd106;
      3:       c = 17'd49;
      4:       c = 17'd24;
      5:       c = 17'd12;
      6:       c = 17'd6;
      7:       c = 17'd3;
      8:       c = 17'd1;
      9:       c = 17'd1;
      default: c = 17'd0;
    endcase
    return c;
  endfunction

  // Same constants held with 16 fractional bits; narrower formats round from these.
  function automatic logic [16:0] log_const_q16(input int i);
    logic [16:0] c;
    case (i)
      1:       c = 17'd65536;
      2:       c = 17'd27200;
      3:       c = 17'd12625;
      4:       c = 17'd6102;
      5:       c = 17'd3002;
      6:       c = 17'd1489;
      7:       c = 17'd742;
      8:       c = 17'd370;
      9:       c = 17'd185;
      10:      c = 17'd92;
      11:      c = 17'd46;
      12:      c = 17'd23;
      13:      c = 17'd12;
      14:      c = 17'd6;
      15:      c = 17'd3;
      16:      c = 17'd1;
      default: c = 17'd0;
    endcase
    return c;
  endfunction

  function automatic logic [16:0] log_const(input int i, input int frac_w);
    logic [16:0] hi;
    logic [16:0] res;
    hi = log_const_q16(i);
    if (frac_w == 8) begin
      res = log_const_q8(i);
    end else if (frac_w >= LOG_C_FRAC) begin
      res = hi;
    end else begin
      res = (hi + (17'd1 << (LOG_C_FRAC - 1 - frac_w))) >> (LOG_C_FRAC - frac_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/hwf_l1_lanes.sv
// Combinational sum of per-lane absolute pixel differences for one input beat.
module hwf_l1_lanes
  import hwf_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int LANES = 1,
  localparam int SUM_W = PIX_W + clog2(LANES + 1)
) (
  input  logic [LANES*PIX_W-1:0] lanes_a,
  input  logic [LANES*PIX_W-1:0] lanes_b,
  output logic [SUM_W-1:0]       l1_sum
);

  logic [PIX_W-1:0] a_s;
  logic [PIX_W-1:0] b_s;
  logic [PIX_W-1:0] diff_s;

  // Unsigned compare-and-subtract per lane, accumulated across the beat.
  always_comb begin
    l1_sum = '0;
    a_s    = '0;
    b_s    = '0;
    diff_s = '0;
    for (int l = 0; l < LANES; l++) begin
      a_s = lanes_a[l*PIX_W +: PIX_W];
      b_s = lanes_b[l*PIX_W +: PIX_W];
      if (a_s >= b_s) begin
        diff_s = a_s - b_s;
      end else begin
        diff_s = b_s - a_s;
      end
      l1_sum = l1_sum + SUM_W'(diff_s);
    end
  end

endmodule

// File: rtl/hwf_kernel_engine.sv
// Streaming HWF SVM kernel: out = bi * 2^(-gamma * L1(x_test, x_sv)).
// Define HWF_SIGNED_COEF_EN to treat bi as two's-complement (magnitude processed, sign reapplied).
module hwf_kernel_engine
  import hwf_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int LANES       = 1,
  parameter int NUM_PIXELS  = 64,
  parameter int COEF_W      = 16,
  parameter int FRAC_W      = 8,
  parameter int ITER        = 8,
  parameter int GAMMA_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COEF_W-1:0]      bi,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] x_test,
  input  logic [LANES*PIX_W-1:0] x_sv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COEF_W-1:0]      kern_out,
  output logic                   busy
);

  localparam int NUM_BEATS = NUM_PIXELS / LANES;
  localparam int NORM_W    = PIX_W + clog2(NUM_PIXELS + 1);
  localparam int SUM_W     = PIX_W + clog2(LANES + 1);
  localparam int E_W       = NORM_W + FRAC_W;
  localparam int BEAT_W    = clog2(NUM_BEATS + 1);
  localparam int ITER_W    = clog2(ITER + 1);

  state_e              state_r;
  logic [NORM_W-1:0]   norm_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [ITER_W-1:0]   iter_cnt_r;
  logic [COEF_W-1:0]   mag_r;
  logic [COEF_W-1:0]   b_r;
  logic [FRAC_W-1:0]   r_r;
  logic [COEF_W-1:0]   kern_out_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                busy_r;
`ifdef HWF_SIGNED_COEF_EN
  logic                neg_r;
  logic                neg_in_s;
`endif

  logic [SUM_W-1:0]    lane_sum_s;
  logic [E_W-1:0]      e_s;
  logic [NORM_W-1:0]   ip_s;
  logic [FRAC_W-1:0]   f_s;
  logic [COEF_W-1:0]   b_shift_s;
  logic [16:0]         c_full_s;
  logic                sub_en_s;
  logic                beat_acc_s;
  logic                last_beat_s;
  logic                last_iter_s;
  logic [COEF_W-1:0]   mag_in_s;
  logic [COEF_W-1:0]   kern_done_s;

  hwf_l1_lanes #(
    .PIX_W (PIX_W),
    .LANES (LANES)
  ) u_l1_lanes (
    .lanes_a (x_test),
    .lanes_b (x_sv),
    .l1_sum  (lane_sum_s)
  );

  // Coefficient magnitude on capture and signed result on completion.
  always_comb begin
`ifdef HWF_SIGNED_COEF_EN
    neg_in_s = bi[COEF_W-1];
    if (bi == {1'b1, {(COEF_W-1){1'b0}}}) begin
      mag_in_s = {1'b0, {(COEF_W-1){1'b1}}};
    end else if (bi[COEF_W-1]) begin
      mag_in_s = -bi;
    end else begin
      mag_in_s = bi;
    end
    if (neg_r) begin
      kern_done_s = -b_r;
    end else begin
      kern_done_s = b_r;
    end
`else
    mag_in_s    = bi;
    kern_done_s = b_r;
`endif
  end

  // Exponent split, integer pre-shift and current log-constant compare.
  always_comb begin
    e_s         = {norm_r, {FRAC_W{1'b0}}} >> GAMMA_SHIFT;
    ip_s        = e_s[E_W-1:FRAC_W];
    f_s         = e_s[FRAC_W-1:0];
    if (ip_s >= NORM_W'(COEF_W)) begin
      b_shift_s = '0;
    end else begin
      b_shift_s = mag_r >> ip_s;
    end
    c_full_s    = log_const(int'(iter_cnt_r), FRAC_W);
    sub_en_s    = ({{(17-FRAC_W){1'b0}}, r_r} >= c_full_s);
    beat_acc_s  = in_valid & in_ready_r;
    last_beat_s = (beat_cnt_r == BEAT_W'(NUM_BEATS - 1));
    last_iter_s = (iter_cnt_r == ITER_W'(ITER));
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      norm_r      <= '0;
      beat_cnt_r  <= '0;
      iter_cnt_r  <= '0;
      mag_r       <= '0;
      b_r         <= '0;
      r_r         <= '0;
      kern_out_r  <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef HWF_SIGNED_COEF_EN
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_ACCUM;
            mag_r      <= mag_in_s;
`ifdef HWF_SIGNED_COEF_EN
            neg_r      <= neg_in_s;
`endif
            norm_r     <= '0;
            beat_cnt_r <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (beat_acc_s) begin
            norm_r     <= norm_r + NORM_W'(lane_sum_s);
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            if (last_beat_s) begin
              state_r    <= ST_SHIFT;
              in_ready_r <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          b_r        <= b_shift_s;
          r_r        <= f_s;
          iter_cnt_r <= ITER_W'(1);
          state_r    <= ST_EXP;
        end
        ST_EXP: begin
          if (sub_en_s) begin
            b_r <= b_r - (b_r >> iter_cnt_r);
            r_r <= r_r - c_full_s[FRAC_W-1:0];
          end
          iter_cnt_r <= iter_cnt_r + ITER_W'(1);
          if (last_iter_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; it then holds until accepted.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            kern_out_r  <= kern_done_s;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign kern_out  = kern_out_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_hwf_kernel_engine.sv
// Randomized scoreboard bench for hwf_kernel_engine against a real-valued kernel model.
module tb_hwf_kernel_engine;

  localparam int PIX_W       = 8;
  localparam int LANES       = 2;
  localparam int NUM_PIXELS  = 4;
  localparam int COEF_W      = 16;
  localparam int FRAC_W      = 8;
  localparam int ITER        = 8;
  localparam int GAMMA_SHIFT = 1;
  localparam int BEATS       = NUM_PIXELS / LANES;
  localparam int TOL         = ITER + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [COEF_W-1:0]      bi;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] x_test;
  logic [LANES*PIX_W-1:0] x_sv;
  logic                   out_valid;
  logic                   out_ready;
  logic [COEF_W-1:0]      kern_out;
  logic                   busy;

  always #5 clk = ~clk;

  hwf_kernel_engine #(
    .PIX_W(PIX_W), .LANES(LANES), .NUM_PIXELS(NUM_PIXELS), .COEF_W(COEF_W),
    .FRAC_W(FRAC_W), .ITER(ITER), .GAMMA_SHIFT(GAMMA_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bi(bi), .in_valid(in_valid),
    .in_ready(in_ready), .x_test(x_test), .x_sv(x_sv), .out_valid(out_valid),
    .out_ready(out_ready), .kern_out(kern_out), .busy(busy)
  );

  int  checks = 0;
  int  errors = 0;
  real ideal_q[$];
  real tol_q[$];
  int  xt_a[NUM_PIXELS];
  int  xs_a[NUM_PIXELS];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: ideal bi * 2^-E from the pixel vectors, exact where the kernel is exact.
  task automatic push_expect(input logic [COEF_W-1:0] coef);
    int  norm;
    int  e_fix;
    int  ip;
    int  mag;
    int  sgn;
    real ideal;
    real tol;
    norm = 0;
    for (int p = 0; p < NUM_PIXELS; p++)
      norm += (xt_a[p] > xs_a[p]) ? xt_a[p] - xs_a[p] : xs_a[p] - xt_a[p];
    e_fix = (norm * (1 << FRAC_W)) >> GAMMA_SHIFT;
    ip    = e_fix / (1 << FRAC_W);
`ifdef HWF_SIGNED_COEF_EN
    mag = int'($signed(coef));
    if (mag == -(1 << (COEF_W - 1))) mag = -((1 << (COEF_W - 1)) - 1);
`else
    mag = int'(coef);
`endif
    sgn = (mag < 0) ? -1 : 1;
    mag = mag * sgn;
    if (norm == 0) begin
      ideal = real'(sgn * mag);
      tol   = 0.0;
    end else if (ip >= COEF_W) begin
      ideal = 0.0;
      tol   = 0.0;
    end else if ((e_fix % (1 << FRAC_W)) == 0) begin
      ideal = real'(sgn * (mag >> ip));
      tol   = 0.0;
    end else begin
      ideal = real'(sgn * mag) * (2.0 ** (-(real'(e_fix) / real'(1 << FRAC_W))));
      tol   = real'(TOL);
    end
    ideal_q.push_back(ideal);
    tol_q.push_back(tol);
  endtask

  // Monitor: checks every cycle a result is presented, randomly back-pressures, pops on handshake.
  initial begin : monitor
    int  kv;
    int  stall_left;
    bit  seen;
    real d;
    out_ready  = 1'b0;
    stall_left = 0;
    seen       = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        out_ready = 1'b0;
        seen      = 1'b0;
      end else if (ideal_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result kern_out=%0h with nothing pending", kern_out);
        out_ready = 1'b1;
      end else begin
        if (!seen) begin
          seen       = 1'b1;
          stall_left = ($urandom_range(0, 2) == 0) ? 5 : $urandom_range(0, 5);
        end
`ifdef HWF_SIGNED_COEF_EN
        kv = int'($signed(kern_out));
`else
        kv = int'(kern_out);
`endif
        d = real'(kv) - ideal_q[0];
        if (d < 0.0) d = -d;
        checks++;
        if (d > tol_q[0] + 0.001) begin
          errors++;
          $display("FAIL kern_out actual=%0d expected=%0f tol=%0f", kv, ideal_q[0], tol_q[0]);
        end
        if (stall_left > 0) begin
          stall_left--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          void'(ideal_q.pop_front());
          void'(tol_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk(name, 1, 0);
  endtask

  task automatic drive_beat(input int b);
    for (int l = 0; l < LANES; l++) begin
      x_test[l*PIX_W +: PIX_W] = PIX_W'(xt_a[b*LANES + l]);
      x_sv[l*PIX_W +: PIX_W]   = PIX_W'(xs_a[b*LANES + l]);
    end
  endtask

  // Driver: one full evaluation with random in_valid gaps and an optional stray start.
  task automatic run_eval(input logic [COEF_W-1:0] coef, input bit poke_start);
    int lat;
    wait_idle("idle_timeout");
    start = 1'b1;
    bi    = coef;
    @(negedge clk);
    start = 1'b0;
    bi    = COEF_W'($urandom);
    push_expect(coef);
    chk("busy_after_start", int'(busy), 1);
    for (int b = 0; b < BEATS; b++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      if (poke_start && b == 0) begin
        start = 1'b1;
        bi    = ~coef;
      end
      chk("in_ready_accum", int'(in_ready), 1);
      in_valid = 1'b1;
      drive_beat(b);
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("in_ready_drop", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, ITER + 2);
  endtask

  task automatic set_pix(input int mode);
    int d;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      xt_a[p] = $urandom_range(0, 255);
      if (mode == 0) begin
        xs_a[p] = xt_a[p];
      end else if (mode == 1) begin
        d       = $urandom_range(0, 8) - 4;
        xs_a[p] = xt_a[p] + d;
        if (xs_a[p] < 0) xs_a[p] = 0;
        if (xs_a[p] > 255) xs_a[p] = 255;
      end else begin
        xs_a[p] = $urandom_range(0, 255);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [COEF_W-1:0] coef;
    int                sv;
    int                guard;
    rst      = 1'b1;
    start    = 1'b0;
    bi       = '0;
    in_valid = 1'b0;
    x_test   = '0;
    x_sv     = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_kern_out", int'(kern_out), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    set_pix(0);
    run_eval(16'h0100, 1'b0);
    set_pix(0);
    xs_a[1] = (xt_a[1] >= 2) ? xt_a[1] - 2 : xt_a[1] + 2;
    run_eval(16'h0100, 1'b0);
    set_pix(0);
    xs_a[2] = (xt_a[2] >= 1) ? xt_a[2] - 1 : xt_a[2] + 1;
    run_eval(16'h0100, 1'b0);
    for (int p = 0; p < NUM_PIXELS; p++) begin
      xt_a[p] = 0;
      xs_a[p] = 255;
    end
    run_eval(16'h0100, 1'b0);
    set_pix(0);
    xs_a[3] = (xt_a[3] >= 2) ? xt_a[3] - 2 : xt_a[3] + 2;
    run_eval(16'hFF00, 1'b0);
    set_pix(0);
    run_eval(16'h8000, 1'b1);
    set_pix(0);
    run_eval(16'hFFFF, 1'b0);

    // Abort mid-ACCUM: no result may appear and everything returns to reset values.
    wait_idle("idle_timeout");
    set_pix(1);
    start = 1'b1;
    bi    = 16'h1234;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    drive_beat(0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_kern_out", int'(kern_out), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    set_pix(1);
    run_eval(16'h00C0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      set_pix(($urandom_range(0, 5) == 0) ? 2 : 1);
`ifdef HWF_SIGNED_COEF_EN
      sv   = $urandom_range(0, 510) - 255;
      coef = sv[COEF_W-1:0];
`else
      sv   = $urandom_range(0, 255);
      coef = sv[COEF_W-1:0];
`endif
      run_eval(coef, $urandom_range(0, 2) == 0);
    end

    guard = 0;
    while (ideal_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("pending_results", ideal_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
